// File: rtl/store_buffer_if.sv
// MEM-stage request bus of the store buffer.
//   req_valid/req_we/req_addr/req_sel/req_wdata : access issued by MEM
//   req_ready : access accepted this cycle (0 = MEM holds the request)
//   rdata_o   : combinational load data, valid with an accepted load
// Modports: master = MEM stage, slave = store buffer.
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_sel;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic [DATA_W-1:0] rdata_o;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata,
    input  req_ready, rdata_o
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata,
    output req_ready, rdata_o
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM and the data RAM.
// Stores are queued and retire to the RAM in cycles where MEM has no accepted
// access; loads use the RAM immediately and are byte-merged with pending
// stores so MEM always observes program-order data.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   mem         : MEM request bus (slave side)
//   fence_i     : hold new accesses until the buffer has drained
//   empty_o     : no pending stores
//   ram_*       : data RAM port (combinational read via ram_rdata)
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  store_buffer_if.slave     mem,
  input  logic              fence_i,
  output logic              empty_o,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int WA_W = ADDR_W - 2;

  // Entry validity is implied by count_q and the pointers.
  logic [WA_W-1:0]   ent_addr_q [DEPTH];
  logic [3:0]        ent_sel_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty, full, fence_blocking, ready;
  logic access_acc, load_acc, store_acc, drain;
  logic [DATA_W-1:0] fwd_data;

  assign empty          = (count_q == '0);
  assign full           = (count_q == CW'(DEPTH));
  assign fence_blocking = fence_i & ~empty;

  // Gated by rst so every output is quiet while reset is asserted.
  assign ready      = rst & ~fence_blocking & ~(mem.req_we & full);
  assign access_acc = mem.req_valid & ready;
  assign load_acc   = access_acc & ~mem.req_we;
  assign store_acc  = access_acc & mem.req_we;
  // Retire the head whenever MEM is idle or stalled this cycle.
  assign drain      = rst & ~empty & ~access_acc;

  assign mem.req_ready = ready;
  assign empty_o       = empty;

  // RAM port arbitration: accepted load, else drain, else idle.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (load_acc) begin
      ram_ce   = 1'b1;
      ram_addr = mem.req_addr;
      ram_sel  = 4'hF;
    end else if (drain) begin
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
      ram_sel   = ent_sel_q[rd_ptr_q];
      ram_wdata = ent_data_q[rd_ptr_q];
    end
  end

  // Walk from oldest to youngest so later matches override earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_data = ram_rdata;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_addr_q[idx] == mem.req_addr[ADDR_W-1:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (ent_sel_q[idx][b]) begin
            fwd_data[8*b +: 8] = ent_data_q[idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign mem.rdata_o = load_acc ? fwd_data : '0;

  always_comb begin
    wr_ptr_d = store_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (store_acc && !drain) begin
      count_d = count_q + CW'(1);
    end else if (!store_acc && drain) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_sel_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      if (store_acc) begin
        ent_addr_q[wr_ptr_q] <= mem.req_addr[ADDR_W-1:2];
        ent_sel_q[wr_ptr_q]  <= mem.req_sel;
        ent_data_q[wr_ptr_q] <= mem.req_wdata;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
